// File: rtl/meas_frame_tx_if.sv
// FIFO write-side link between the telemetry framer (master) and the FT245 async FIFO (slave).
interface meas_frame_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_full;

    modport master (output wr_en, output wr_data, input wr_full);
    modport slave  (input wr_en, input wr_data, output wr_full);
endinterface

// File: rtl/meas_frame_tx.sv
// Outbound telemetry framer: captures NUM_SAMPLES 12-bit samples plus a status snapshot
// and streams them as a checksummed byte frame into the FT245 FIFO write port.
module meas_frame_tx #(
    parameter int         NUM_SAMPLES = 8,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  sample_valid,
    input  logic [11:0]           sample_data,
    input  logic [3:0]            controlstate,
    input  logic [9:0]            ps_dig,
    input  logic                  ps_en,
    input  logic                  fg_en,
    input  logic [1:0]            relay,
    meas_frame_tx_if.master       fifo,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int FRAME_LEN = 7 + 2 * NUM_SAMPLES;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int CNT_W     = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SEND
    } state_t;

    state_t           state;
    logic [11:0]      samples [NUM_SAMPLES];
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] byte_idx;
    logic [7:0]       seq;
    logic [7:0]       status_snap;
    logic [9:0]       ps_snap;
    logic [7:0]       checksum;
    logic [7:0]       wr_data_q;
    logic             drop_flag;

    logic             accept;
    logic             drop_now;
    logic             store_sample;
    logic [IDX_W-1:0] nidx;
    logic [IDX_W-1:0] samp_off;
    logic [CNT_W-1:0] samp_sel;
    logic [7:0]       next_byte;

    assign accept       = (state == SEND) & ~fifo.wr_full;
    assign fifo.wr_en   = accept;
    assign fifo.wr_data = wr_data_q;
    assign busy         = (state == SEND);

    // A sample arriving while we cannot store it is lost; every IDLE cycle with enable
    // high is an entry cycle, so it counts there as well as in SEND.
    assign drop_now     = sample_valid & enable & ((state == SEND) | (state == IDLE));
    assign store_sample = (state == CAPTURE) & enable & sample_valid;

    // The byte that follows the one currently on wr_data; loaded when that one is accepted.
    always_comb begin
        nidx      = byte_idx + IDX_W'(1);
        samp_off  = nidx - IDX_W'(6);
        samp_sel  = CNT_W'(samp_off >> 1);
        next_byte = 8'h00;
        if (nidx == IDX_W'(1))
            next_byte = drop_flag ? 8'h4F : 8'h4D;
        else if (nidx == IDX_W'(2))
            next_byte = seq;
        else if (nidx == IDX_W'(3))
            next_byte = status_snap;
        else if (nidx == IDX_W'(4))
            next_byte = {6'b0, ps_snap[9:8]};
        else if (nidx == IDX_W'(5))
            next_byte = ps_snap[7:0];
        else if (nidx == LAST_IDX)
            next_byte = checksum + wr_data_q;
        else if (nidx < LAST_IDX)
            next_byte = samp_off[0] ? samples[samp_sel][7:0]
                                    : {4'b0, samples[samp_sel][11:8]};
    end

    always_ff @(posedge clk) begin
        if (store_sample)
            samples[cnt] <= sample_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            byte_idx    <= '0;
            seq         <= 8'h00;
            status_snap <= 8'h00;
            ps_snap     <= 10'h000;
            checksum    <= 8'h00;
            wr_data_q   <= 8'h00;
            drop_flag   <= 1'b0;
            overrun     <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (drop_now) begin
                overrun   <= 1'b1;
                drop_flag <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= CAPTURE;
                        cnt   <= '0;
                    end
                end

                CAPTURE: begin
                    if (!enable) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (sample_valid) begin
                        if (cnt == LAST_CNT) begin
                            status_snap <= {controlstate, ps_en, fg_en, relay[1], relay[0]};
                            ps_snap     <= ps_dig;
                            cnt         <= '0;
                            byte_idx    <= '0;
                            checksum    <= 8'h00;
                            wr_data_q   <= SYNC_BYTE;
                            state       <= SEND;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                SEND: begin
                    if (accept) begin
                        if (byte_idx != '0)
                            checksum <= checksum + wr_data_q;
                        // Type byte already carries the old flag; only drops in this cycle survive.
                        if (byte_idx == IDX_W'(1))
                            drop_flag <= drop_now;
                        if (byte_idx == LAST_IDX) begin
                            frame_done <= 1'b1;
                            seq        <= seq + 8'd1;
                            byte_idx   <= '0;
                            state      <= enable ? CAPTURE : IDLE;
                        end else begin
                            wr_data_q <= next_byte;
                            byte_idx  <= byte_idx + IDX_W'(1);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
